// File: rtl/hd_dma.sv
// hd_dma: two-memory word DMA between a disk store and main memory.
// Each word takes one RD cycle (source address out) and one WR cycle
// (destination address out, source read data forwarded, one strobe).
// Optional feature macro: HD_DMA_CHECKSUM_EN adds a running checksum
// output of every word written during the transfer.
module hd_dma #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  dir,
  input  logic [ADDR_WIDTH-1:0] hd_base,
  input  logic [ADDR_WIDTH-1:0] mem_base,
  input  logic [ADDR_WIDTH:0]   length,
  output logic [DATA_WIDTH-1:0] hd_addr,
  output logic [DATA_WIDTH-1:0] hd_data,
  output logic                  hd_write,
  input  logic [DATA_WIDTH-1:0] data_HD,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_write,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  busy,
  output logic                  done
`ifdef HD_DMA_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] checksum
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ONE_A = 1;
  localparam logic [ADDR_WIDTH:0]   ONE_C = 1;

  state_t                  state_q;
  logic                    dir_q;
  logic [ADDR_WIDTH-1:0]   hd_ptr_q, hd_ptr_d;
  logic [ADDR_WIDTH-1:0]   mem_ptr_q, mem_ptr_d;
  logic [ADDR_WIDTH:0]     cnt_q, cnt_d;
  logic                    busy_q;
  logic                    done_q;
  logic [DATA_WIDTH-1:0]   wdata;

`ifdef HD_DMA_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]   csum_q;
`endif

  // Next pointer/count values; pointers wrap naturally at ADDR_WIDTH bits.
  always_comb begin
    hd_ptr_d  = hd_ptr_q + ONE_A;
    mem_ptr_d = mem_ptr_q + ONE_A;
    cnt_d     = cnt_q - ONE_C;
  end

  // Word being written this WR cycle: the source memory's read data.
  always_comb begin
    wdata = dir_q ? mem_q : data_HD;
  end

  // Transfer FSM with registered busy/done flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      dir_q     <= 1'b0;
      hd_ptr_q  <= '0;
      mem_ptr_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef HD_DMA_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            dir_q     <= dir;
            hd_ptr_q  <= hd_base;
            mem_ptr_q <= mem_base;
            cnt_q     <= length;
`ifdef HD_DMA_CHECKSUM_EN
            csum_q    <= '0;
`endif
            if (length != '0) begin
              state_q <= RD;
              busy_q  <= 1'b1;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        RD: begin
          state_q <= WR;
        end
        WR: begin
          hd_ptr_q  <= hd_ptr_d;
          mem_ptr_q <= mem_ptr_d;
          cnt_q     <= cnt_d;
`ifdef HD_DMA_CHECKSUM_EN
          csum_q    <= csum_q + wdata;
`endif
          if (cnt_d != '0) begin
            state_q <= RD;
          end else begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Memory-side outputs decoded from registered state only; the write data
  // must be combinational because source read data arrives during WR.
  always_comb begin
    hd_addr   = '0;
    mem_addr  = '0;
    hd_data   = '0;
    mem_data  = '0;
    hd_write  = 1'b0;
    mem_write = 1'b0;
    if (state_q == RD || state_q == WR) begin
      hd_addr  = DATA_WIDTH'(hd_ptr_q);
      mem_addr = DATA_WIDTH'(mem_ptr_q);
    end
    if (state_q == WR) begin
      if (dir_q) begin
        hd_write = 1'b1;
        hd_data  = wdata;
      end else begin
        mem_write = 1'b1;
        mem_data  = wdata;
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;

`ifdef HD_DMA_CHECKSUM_EN
  assign checksum = csum_q;
`endif

endmodule

// File: doc/hd_dma.md
HD_DMA -- requirements
Module: hd_dma

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, the word width of both memories.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 13, the word-address width of both memories.
REQ-003 Port clock, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port start, input, 1: single-cycle request to begin a transfer; sampled only in IDLE.
REQ-006 Port dir, input, 1: 0 = disk to memory (load), 1 = memory to disk (store).
REQ-007 Port hd_base, input, ADDR_WIDTH: first disk word address.
REQ-008 Port mem_base, input, ADDR_WIDTH: first memory word address.
REQ-009 Port length, input, ADDR_WIDTH+1: word count, 0 to 2^ADDR_WIDTH.
REQ-010 Port hd_addr, output, DATA_WIDTH: disk address, zero-extended.
REQ-011 Port hd_data, output, DATA_WIDTH: disk write data.
REQ-012 Port hd_write, output, 1: disk write strobe.
REQ-013 Port data_HD, input, DATA_WIDTH: disk read data, valid one cycle after hd_addr is presented.
REQ-014 Port mem_addr, output, DATA_WIDTH: memory address, zero-extended.
REQ-015 Port mem_data, output, DATA_WIDTH: memory write data.
REQ-016 Port mem_write, output, 1: memory write strobe.
REQ-017 Port mem_q, input, DATA_WIDTH: memory read data, valid one cycle after mem_addr is presented.
REQ-018 Port busy, output, 1: high from the cycle after an accepted start until DONE.
REQ-019 Port done, output, 1: one-cycle pulse when a transfer completes.

Function
REQ-020 The FSM SHALL have states IDLE, RD, WR and DONE.
REQ-021 IDLE with start=1 SHALL latch dir, hd_base, mem_base and length, then go to RD if length>0, or to DONE if length=0.
REQ-022 RD SHALL present the current source address: hd_addr for load, mem_addr for store.
REQ-023 RD SHALL hold both write strobes low and SHALL go to WR unconditionally.
REQ-024 WR SHALL present the destination address and drive the source read data (data_HD or mem_q) onto the destination data port.
REQ-025 WR SHALL assert exactly one strobe, mem_write for load or hd_write for store.
REQ-026 WR SHALL increment both addresses and decrement the remaining count.
REQ-027 WR SHALL go to RD if the remaining count after decrement is nonzero, else to DONE.
REQ-028 DONE SHALL assert done for exactly one cycle, deassert busy, and return to IDLE.
REQ-029 Throughput SHALL be exactly 2 cycles per word; a transfer of N>0 words SHALL take 2N+1 cycles from the start edge to the done pulse.
REQ-030 Address increments SHALL wrap modulo 2^ADDR_WIDTH.
REQ-031 start asserted outside IDLE SHALL be ignored, with no effect on the transfer in progress.
REQ-032 Write strobes SHALL be decoded from the registered state only, never from start or any other input.
REQ-033 In IDLE and DONE both strobes SHALL be low, and hd_data and mem_data SHALL be zero.

Reset
REQ-034 On reset the state SHALL become IDLE and all latched registers SHALL be cleared.
REQ-035 Reset SHALL force hd_write=0, mem_write=0, busy=0 and done=0, and all address/data outputs to 0, from the cycle after the reset edge.
REQ-036 Reset during RD or WR SHALL abort the transfer without a done pulse; words already written SHALL remain written.

Configuration
REQ-037 With macro HD_DMA_CHECKSUM_EN defined, an output checksum [DATA_WIDTH-1:0] SHALL exist.
REQ-038 checksum SHALL be cleared on an accepted start, accumulate the modulo-2^DATA_WIDTH sum of every word written in WR, and hold until the next start or reset.
REQ-039 Without HD_DMA_CHECKSUM_EN, the checksum port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-040 Load: disk words 5..7 = A,B,C; start, dir=0, hd_base=5, mem_base=100, length=3 -> mem[100..102]=A,B,C, done exactly 7 cycles after start, hd_write never high.
REQ-041 Store: mem[0..1]=X,Y; start, dir=1, mem_base=0, hd_base=8190, length=2 -> hd[8190]=X, hd[8191]=Y, done after 5 cycles.
REQ-042 Wrap: load with hd_base=8191, length=2 -> reads hd[8191] then hd[0]; start=1 held high throughout -> no restart until IDLE.
REQ-043 Zero length: start with length=0 -> done pulses on the next cycle, no strobe ever asserted.
REQ-044 Reset mid-transfer: load of length=4, reset on the 4th cycle of the transfer -> only mem[base] written, busy=0, done never pulses.
REQ-045 Checksum (macro defined): load of words 1,2,0xFFFFFFFF -> checksum=2 at done.
